// File: rtl/uart_mmio_bridge_if.sv
// Bus bundle between the CPU data port / UART PHY (master side) and the
// memory-mapped UART bridge (slave side).
interface uart_mmio_bridge_if;
  // Handshake semantics: ram_en marks a single-cycle access that the bridge
  // always accepts in that same cycle (no backpressure, no ready); read data
  // is combinational in that cycle. rx_ready is a level meaning "byte held",
  // and rx_clear acknowledges it combinationally in the same cycle.
  logic        ram_en;
  logic        ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_i;
  logic [3:0]  ram_select;
  logic        uart_sel;
  logic [31:0] uart_rdata;

  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_clear;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_data_i, ram_select,
    output tx_busy, rx_ready, rx_data,
    input  uart_sel, uart_rdata, tx_start, tx_data, rx_clear
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_data_i, ram_select,
    input  tx_busy, rx_ready, rx_data,
    output uart_sel, uart_rdata, tx_start, tx_data, rx_clear
  );
endinterface

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART bridge: data/status registers, a small RX FIFO with a
// sticky overrun flag, and a start-pulse sequencer for the transmitter.
module uart_mmio_bridge #(
  parameter logic [31:0] DATA_ADDR = 32'hBFD003F8,
  parameter logic [31:0] STAT_ADDR = 32'hBFD003FC,
  parameter int          RX_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_mmio_bridge_if.slave  bus,
  output logic [1:0]         dbg_state
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam logic [PW:0] FULL_COUNT = RX_DEPTH[PW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

  // Address decode
  logic hit_data;
  logic hit_stat;
  logic data_rd;
  logic stat_rd;
  logic data_wr;

  assign hit_data     = (bus.ram_addr == DATA_ADDR);
  assign hit_stat     = (bus.ram_addr == STAT_ADDR);
  assign bus.uart_sel = bus.ram_en && (hit_data || hit_stat);
  assign data_rd      = bus.ram_en && !bus.ram_write_en && hit_data;
  assign stat_rd      = bus.ram_en && !bus.ram_write_en && hit_stat;
  assign data_wr      = bus.ram_en && bus.ram_write_en && hit_data;

  logic unused_bus;
  assign unused_bus = ^{bus.ram_select, bus.ram_data_i[31:8]};

  // RX FIFO
  logic [7:0]    mem [RX_DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW:0]   count;
  logic          overrun;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          ov_set;

  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);
  assign pop    = data_rd && !empty;
  // A full FIFO still accepts a byte when the same cycle frees an entry.
  assign push   = bus.rx_ready && (!full || pop);
  assign ov_set = bus.rx_ready && full && !pop;
  assign bus.rx_clear = bus.rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set wins over the clear-on-status-read.
      if (ov_set)       overrun <= 1'b1;
      else if (stat_rd) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.rx_data;
  end

  // TX sequencer
  tx_state_e  state;
  tx_state_e  state_next;
  logic       tx_pending;
  logic [7:0] tx_hold;
  logic [7:0] tx_data_q;
  logic       tx_ready;
  logic       enter_start;

  assign tx_ready = (state == IDLE) && !tx_pending && !bus.tx_busy;

  always_comb begin
    state_next  = state;
    enter_start = 1'b0;
    case (state)
      IDLE: begin
        if (tx_pending && !bus.tx_busy) begin
          state_next  = START;
          enter_start = 1'b1;
        end
      end
      START:   state_next = GAP;
      GAP:     state_next = DRAIN;
      DRAIN:   if (!bus.tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tx_pending <= 1'b0;
      tx_hold    <= '0;
      tx_data_q  <= '0;
    end else begin
      state <= state_next;
      if (data_wr && tx_ready) begin
        tx_hold    <= bus.ram_data_i[7:0];
        tx_pending <= 1'b1;
      end else if (enter_start) begin
        tx_pending <= 1'b0;
      end
      if (enter_start) tx_data_q <= tx_hold;
    end
  end

  // tx_start decodes straight from state so reset kills it asynchronously.
  assign bus.tx_start = (state == START);
  assign bus.tx_data  = tx_data_q;
  assign dbg_state    = state;

  always_comb begin
    bus.uart_rdata = '0;
    if (stat_rd) begin
      bus.uart_rdata = {29'b0, overrun, !empty, tx_ready};
    end else if (data_rd && !empty) begin
      bus.uart_rdata = {24'b0, mem[rptr]};
    end
  end

endmodule
